// File: rtl/cw_byte_packer.sv
// Repacks constant-weight codewords into an MSB-first byte stream with a small
// {last,byte} FIFO, zero padding of the final byte and sticky overflow reporting.
`timescale 1ns/1ps

module cw_byte_packer #(
  parameter int CW_W       = 20,
  parameter int ACC_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CW_W-1:0] cw_in,
  input  logic            cw_rdy,
  input  logic            cw_done,
  output logic [7:0]      byte_out,
  output logic            byte_valid,
  input  logic            byte_ready,
  output logic            byte_last,
  output logic            busy,
  output logic            frame_done,
  output logic            overflow,
  output logic [7:0]      cw_count
);

  // state   | meaning
  // IDLE    | waiting for start
  // COLLECT | appending codewords, extracting whole bytes
  // FLUSH   | encoder done; emptying acc, padding the tail byte
  // DRAIN   | last byte queued; waiting for it to be popped
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH, S_DRAIN} state_t;

  localparam int CNT_W  = $clog2(ACC_W + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]  BYTE_BITS = CNT_W'(8);
  localparam logic [CNT_W-1:0]  CW_BITS   = CNT_W'(CW_W);
  localparam logic [CNT_W-1:0]  ROOM      = CNT_W'(ACC_W - CW_W);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [8:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [FCNT_W-1:0]  fifo_cnt;

  logic               pop, space, in_frame, ext, pad, push, push_last, take, fits;
  logic [7:0]         push_byte;
  logic [CNT_W-1:0]   cnt_x, cnt_n;
  logic [ACC_W-1:0]   acc_x, acc_n, cw_al;
  logic [PTR_W-1:0]   rd_nx;
  logic [FCNT_W-1:0]  fifo_rem, fifo_cnt_n;
  logic [8:0]         head_n;

  assign byte_valid = (fifo_cnt != '0);
  assign busy       = (state != S_IDLE);
  assign cw_al      = {cw_in, {(ACC_W-CW_W){1'b0}}};

  always_comb begin
    pop       = byte_valid && byte_ready;
    space     = (fifo_cnt != FIFO_FULL) || pop;
    in_frame  = (state == S_COLLECT) || (state == S_FLUSH);
    ext       = in_frame && (cnt >= BYTE_BITS) && space;
    // bits below cnt are always zero, so the top byte is already padded
    pad       = (state == S_FLUSH) && (cnt < BYTE_BITS) && space;
    push      = ext || pad;
    push_byte = acc[ACC_W-1 -: 8];
    push_last = (state == S_FLUSH) && (pad || (cnt == BYTE_BITS));
    cnt_x     = ext ? (cnt - BYTE_BITS) : cnt;
    acc_x     = ext ? (acc << 8) : acc;
    take      = (state == S_COLLECT) && cw_rdy;
    fits      = (cnt_x <= ROOM);
    acc_n     = acc_x;
    cnt_n     = cnt_x;
    if (pad) begin
      acc_n = '0;
      cnt_n = '0;
    end else if (take && fits) begin
      acc_n = acc_x | (cw_al >> cnt_x);
      cnt_n = cnt_x + CW_BITS;
    end
    rd_nx      = rd_ptr + PTR_W'(pop);
    fifo_rem   = fifo_cnt - FCNT_W'(pop);
    fifo_cnt_n = fifo_rem + FCNT_W'(push);
    // next head comes from storage unless the FIFO is about to run dry
    head_n     = (fifo_rem != '0) ? mem[rd_nx] : {push_last, push_byte};
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_last, push_byte};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      acc        <= '0;
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      byte_out   <= '0;
      byte_last  <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      cw_count   <= '0;
    end else begin
      frame_done <= 1'b0;
      acc        <= acc_n;
      cnt        <= cnt_n;
      rd_ptr     <= rd_nx;
      fifo_cnt   <= fifo_cnt_n;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_cnt_n != '0) {byte_last, byte_out} <= head_n;
      else                  byte_last <= 1'b0;
      if (take && fits && (cw_count != 8'hFF)) cw_count <= cw_count + 8'd1;
      if (take && !fits) overflow <= 1'b1;

      case (state)
        S_IDLE: if (start) begin
          state    <= S_COLLECT;
          acc      <= '0;
          cnt      <= '0;
          cw_count <= '0;
          overflow <= 1'b0;
        end
        S_COLLECT: if (cw_done) state <= S_FLUSH;
        S_FLUSH:   if (push && push_last) state <= S_DRAIN;
        S_DRAIN: if (pop && byte_last) begin
          state      <= S_IDLE;
          frame_done <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cw_byte_packer.sv
// Directed bench for cw_byte_packer: table of frames checked against hand values
// and a bit-serial packing model, plus reset / ignored-input sequences.
`timescale 1ns/1ps

module tb_cw_byte_packer;
  localparam int CW_W = 20;

  logic            clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic            cw_rdy = 1'b0, cw_done = 1'b0, byte_ready = 1'b0;
  logic [CW_W-1:0] cw_in = '0;
  logic [7:0]      byte_out, cw_count;
  logic            byte_valid, byte_last, busy, frame_done, overflow;

  cw_byte_packer #(.CW_W(CW_W), .ACC_W(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .cw_in(cw_in), .cw_rdy(cw_rdy),
    .cw_done(cw_done), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .byte_last(byte_last), .busy(busy),
    .frame_done(frame_done), .overflow(overflow), .cw_count(cw_count));

  always #5 clk = ~clk;

  typedef struct {
    int         n_cw;
    logic [19:0] cw;
    int         gap;
    bit         done_last;
    int         st_lo;
    int         st_len;
    bit         chk_hold;
    int         exp_bytes;
    logic [7:0] exp_b0;
    logic [7:0] exp_bl;
    int         exp_cnt;
    bit         exp_ovf;
  } vec_t;

  vec_t       vt [8];
  int         n_vec = 0, n_err = 0;
  int         cyc = 0, fcyc = 0, st_lo = 0, st_hi = 0;
  int         fd_cnt = 0, fd_cyc = 0, lastpop_cyc = 0;
  bit         hold_chk = 1'b0;
  logic [8:0] hold_v;
  logic [8:0] got_q [$];
  logic [8:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (byte_valid && byte_ready) begin
      got_q.push_back({byte_last, byte_out});
      if (byte_last) lastpop_cyc = cyc;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    fcyc++;
    byte_ready = !(fcyc >= st_lo && fcyc < st_hi);
    if (hold_chk) begin
      if (fcyc == st_lo) begin
        hold_v = {byte_last, byte_out};
        chk("stall_valid", 32'(byte_valid), 32'd1);
      end else if (fcyc > st_lo && fcyc <= st_hi) begin
        chk("stall_hold", 32'({byte_last, byte_out}), 32'(hold_v));
      end
    end
  endtask

  // bit-serial reference: first n codewords, MSB first, zero-padded tail
  task automatic build_exp(input int n, input logic [19:0] cw);
    logic       bits [$];
    logic [7:0] by;
    exp_q.delete();
    for (int i = 0; i < n; i++)
      for (int b = CW_W - 1; b >= 0; b--) bits.push_back(cw[b]);
    if (bits.size() == 0) exp_q.push_back(9'h100);
    while (bits.size() > 0) begin
      by = '0;
      for (int k = 0; k < 8; k++)
        by = {by[6:0], (bits.size() > 0) ? bits.pop_front() : 1'b0};
      exp_q.push_back({(bits.size() == 0), by});
    end
  endtask

  task automatic finish_frame(input int exp_bytes, input logic [7:0] b0, input logic [7:0] bl,
                              input int ecnt, input bit eovf);
    int guard = 0;
    int mism  = 0;
    int nlast = 0;
    while (fd_cnt == 0 && guard < 300) begin
      tick();
      guard++;
    end
    chk("frame_done_timeout", 32'(guard < 300), 32'd1);
    tick();
    tick();
    chk("n_bytes", 32'(got_q.size()), 32'(exp_bytes));
    if (got_q.size() > 0) begin
      chk("first_byte", 32'(got_q[0][7:0]), 32'(b0));
      chk("final_byte", 32'(got_q[got_q.size()-1][7:0]), 32'(bl));
      chk("final_last", 32'(got_q[got_q.size()-1][8]), 32'd1);
    end
    foreach (got_q[i]) if (got_q[i][8]) nlast++;
    chk("last_count", 32'(nlast), 32'd1);
    if (got_q.size() != exp_q.size()) mism++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    chk("stream_vs_model", 32'(mism), 32'd0);
    chk("cw_count", 32'(cw_count), 32'(ecnt));
    chk("overflow", 32'(overflow), 32'(eovf));
    chk("frame_done_pulses", 32'(fd_cnt), 32'd1);
    chk("frame_done_delay", 32'(fd_cyc - lastpop_cyc), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic new_frame(input int lo, input int len);
    got_q.delete();
    fd_cnt = 0;
    fcyc   = 0;
    st_lo  = lo;
    st_hi  = lo + len;
    byte_ready = !(0 >= st_lo && 0 < st_hi);
  endtask

  task automatic run_vec(input vec_t v);
    new_frame(v.st_lo, v.st_len);
    hold_chk = v.chk_hold;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < v.n_cw; i++) begin
      cw_in   = v.cw;
      cw_rdy  = 1'b1;
      cw_done = v.done_last && (i == v.n_cw - 1);
      tick();
      cw_rdy  = 1'b0;
      cw_done = 1'b0;
      repeat (v.gap - 1) tick();
    end
    if (!v.done_last || v.n_cw == 0) begin
      tick();
      cw_done = 1'b1;
      tick();
      cw_done = 1'b0;
    end
    build_exp(v.exp_cnt, v.cw);
    finish_frame(v.exp_bytes, v.exp_b0, v.exp_bl, v.exp_cnt, v.exp_ovf);
    hold_chk = 1'b0;
  endtask

  initial begin
    //           n   cw        gap done lo len hold bytes b0     blast  cnt ovf
    vt[0] = '{10, 20'hA5A5A, 8, 1, 0, 0,  0, 25, 8'hA5, 8'h5A, 10, 0};
    vt[1] = '{3,  20'hFFFFF, 4, 0, 0, 0,  0, 8,  8'hFF, 8'hF0, 3,  0};
    vt[2] = '{2,  20'h12345, 3, 1, 0, 0,  0, 5,  8'h12, 8'h45, 2,  0};
    vt[3] = '{0,  20'h00000, 1, 0, 0, 0,  0, 1,  8'h00, 8'h00, 0,  0};
    vt[4] = '{1,  20'h0000F, 2, 1, 0, 0,  0, 3,  8'h00, 8'hF0, 1,  0};
    vt[5] = '{4,  20'hABCDE, 1, 1, 0, 0,  0, 5,  8'hAB, 8'hDE, 2,  1};
    vt[6] = '{4,  20'h13579, 3, 1, 0, 14, 0, 8,  8'h13, 8'h90, 3,  1};
    vt[7] = '{6,  20'h3C5A9, 3, 1, 7, 5,  1, 15, 8'h3C, 8'hA9, 6,  0};

    new_frame(0, 0);
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_byte_out", 32'(byte_out), 32'd0);
    chk("rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte_last", 32'(byte_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_cw_count", 32'(cw_count), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // cw_rdy alongside the opening start is dropped; a start mid-frame is ignored
    new_frame(0, 0);
    start = 1'b1; cw_rdy = 1'b1; cw_in = 20'hAAAAA;
    tick();
    start = 1'b0; cw_rdy = 1'b0;
    chk("start_cw_ignored", 32'(cw_count), 32'd0);
    cw_rdy = 1'b1; cw_in = 20'hFFFFF;
    tick();
    cw_rdy = 1'b0;
    chk("lat_acc_cycle_valid", 32'(byte_valid), 32'd0);
    tick();
    chk("lat_push_cycle_valid", 32'(byte_valid), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_ignored", 32'(cw_count), 32'd1);
    cw_rdy = 1'b1; cw_done = 1'b1;
    tick();
    cw_rdy = 1'b0; cw_done = 1'b0;
    build_exp(2, 20'hFFFFF);
    finish_frame(5, 8'hFF, 8'hFF, 2, 1'b0);

    // reset while FLUSH is stalled behind a full FIFO
    new_frame(0, 1000);
    start = 1'b1;
    tick();
    start = 1'b0;
    cw_in = 20'hFFFFF; cw_rdy = 1'b1;
    tick();
    cw_rdy = 1'b0;
    repeat (2) tick();
    cw_rdy = 1'b1; cw_done = 1'b1;
    tick();
    cw_rdy = 1'b0; cw_done = 1'b0;
    repeat (3) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_valid", 32'(byte_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 32'(byte_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cw_count", 32'(cw_count), 32'd0);
    st_lo = 0; st_hi = 0;
    cw_rdy = 1'b1; cw_done = 1'b1; cw_in = 20'h12345;
    repeat (3) tick();
    cw_rdy = 1'b0; cw_done = 1'b0;
    tick();
    chk("idle_cw_busy", 32'(busy), 32'd0);
    chk("idle_cw_count", 32'(cw_count), 32'd0);
    chk("idle_cw_valid", 32'(byte_valid), 32'd0);
    chk("no_frame_done_after_rst", 32'(fd_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
